// File: rtl/riscv_obs_tracer.sv
// Retired-instruction observation tracer: decodes each retired instruction into one
// record (address, branch outcome, jump target or result) and queues it for the checker.

module riscv_decoder (
    input  logic [31:0] instr,
    output logic [2:0]  fmt,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [20:0] imm
);
    localparam logic [2:0] TYPE_R   = 3'd0;
    localparam logic [2:0] TYPE_I   = 3'd1;
    localparam logic [2:0] TYPE_S   = 3'd2;
    localparam logic [2:0] TYPE_B   = 3'd3;
    localparam logic [2:0] TYPE_U   = 3'd4;
    localparam logic [2:0] TYPE_J   = 3'd5;
    localparam logic [2:0] TYPE_ERR = 3'd6;

    // imm is the raw immediate field, zero-extended; U-type immediates are not produced.
    always_comb begin
        opcode = instr[6:0];
        funct3 = instr[14:12];
        fmt    = TYPE_ERR;
        imm    = '0;
        case (instr[6:0])
            7'b0110011: fmt = (instr[31:25] == 7'b0000000 || instr[31:25] == 7'b0100000)
                              ? TYPE_R : TYPE_ERR;
            7'b0010011, 7'b0000011, 7'b1100111: begin
                fmt = TYPE_I;
                imm = {9'b0, instr[31:20]};
            end
            7'b0100011: begin
                fmt = TYPE_S;
                imm = {9'b0, instr[31:25], instr[11:7]};
            end
            7'b1100011: begin
                fmt = TYPE_B;
                imm = {8'b0, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: fmt = TYPE_U;
            7'b1101111: begin
                fmt = TYPE_J;
                imm = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: fmt = TYPE_ERR;
        endcase
    end
endmodule

module riscv_obs_tracer #(
    parameter int DEPTH   = 8,
    parameter bit OBS_ALL = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     retire_valid_i,
    input  logic [31:0]              instr_i,
    input  logic [31:0]              pc_i,
    input  logic [31:0]              rs1_val_i,
    input  logic [31:0]              rs2_val_i,
    input  logic [31:0]              rd_val_i,
    output logic                     obs_valid_o,
    input  logic                     obs_ready_i,
    output logic [2:0]               obs_kind_o,
    output logic [31:0]              obs_seq_o,
    output logic [31:0]              obs_pc_o,
    output logic [31:0]              obs_addr_o,
    output logic [31:0]              obs_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [15:0]              drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [2:0] TYPE_ERR  = 3'd6;
    localparam logic [2:0] K_ALU = 3'd0, K_LOAD = 3'd1, K_STORE = 3'd2;
    localparam logic [2:0] K_BRANCH = 3'd3, K_JUMP = 3'd4, K_ILLEGAL = 3'd7;

    // Valid/ready: a record leaves the head on any rising edge where obs_valid_o and
    // obs_ready_i are both high; the head is held unchanged otherwise.

    logic [2:0]  dec_fmt;
    logic [6:0]  dec_op;
    logic [2:0]  dec_f3;
    logic [20:0] dec_imm;

    riscv_decoder u_dec (
        .instr  (instr_i),
        .fmt    (dec_fmt),
        .opcode (dec_op),
        .funct3 (dec_f3),
        .imm    (dec_imm)
    );

    logic [31:0] imm_i, imm_b, imm_j;
    assign imm_i = {{20{dec_imm[11]}}, dec_imm[11:0]};
    assign imm_b = {{19{dec_imm[12]}}, dec_imm[12:0]};
    assign imm_j = {{11{dec_imm[20]}}, dec_imm[20:0]};

    logic        emit, taken, bad_br;
    logic [2:0]  rec_kind;
    logic [31:0] rec_addr, rec_data;

    always_comb begin
        taken  = 1'b0;
        bad_br = 1'b0;
        case (dec_f3)
            3'b000:  taken = (rs1_val_i == rs2_val_i);
            3'b001:  taken = (rs1_val_i != rs2_val_i);
            3'b100:  taken = ($signed(rs1_val_i) <  $signed(rs2_val_i));
            3'b101:  taken = ($signed(rs1_val_i) >= $signed(rs2_val_i));
            3'b110:  taken = (rs1_val_i <  rs2_val_i);
            3'b111:  taken = (rs1_val_i >= rs2_val_i);
            default: bad_br = 1'b1;
        endcase
    end

    always_comb begin
        emit     = 1'b1;
        rec_kind = K_ILLEGAL;
        rec_addr = '0;
        rec_data = instr_i;
        if (dec_fmt != TYPE_ERR) begin
            case (dec_op)
                7'b0000011: begin
                    rec_kind = K_LOAD;
                    rec_addr = rs1_val_i + imm_i;
                    rec_data = rd_val_i;
                end
                7'b0100011: begin
                    rec_kind = K_STORE;
                    rec_addr = rs1_val_i + imm_i;
                    rec_data = rs2_val_i;
                end
                7'b1100011: begin
                    if (!bad_br) begin
                        rec_kind = K_BRANCH;
                        rec_addr = pc_i + imm_b;
                        rec_data = {31'b0, taken};
                    end
                end
                7'b1101111: begin
                    rec_kind = K_JUMP;
                    rec_addr = pc_i + imm_j;
                    rec_data = rd_val_i;
                end
                7'b1100111: begin
                    rec_kind = K_JUMP;
                    rec_addr = (rs1_val_i + imm_i) & ~32'd1;
                    rec_data = rd_val_i;
                end
                default: begin
                    emit     = OBS_ALL;
                    rec_kind = K_ALU;
                    rec_data = rd_val_i;
                end
            endcase
        end
    end

    logic [2:0]  mem_kind [DEPTH];
    logic [31:0] mem_seq  [DEPTH];
    logic [31:0] mem_pc   [DEPTH];
    logic [31:0] mem_addr [DEPTH];
    logic [31:0] mem_data [DEPTH];

    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic [31:0]   seq;
    logic          full, push, do_push, do_pop, drop;

    assign full    = (count == FULL_CNT);
    assign push    = retire_valid_i & emit;
    assign do_pop  = obs_valid_o & obs_ready_i;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_kind[wptr] <= rec_kind;
            mem_seq[wptr]  <= seq;
            mem_pc[wptr]   <= pc_i;
            mem_addr[wptr] <= rec_addr;
            mem_data[wptr] <= rec_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            seq        <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (clear_i) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            seq        <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            if (retire_valid_i) seq <= seq + 32'd1;
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end
    end

    assign obs_valid_o = (count != '0);
    assign count_o     = count;
    assign obs_kind_o  = obs_valid_o ? mem_kind[rptr] : 3'd0;
    assign obs_seq_o   = obs_valid_o ? mem_seq[rptr]  : 32'd0;
    assign obs_pc_o    = obs_valid_o ? mem_pc[rptr]   : 32'd0;
    assign obs_addr_o  = obs_valid_o ? mem_addr[rptr] : 32'd0;
    assign obs_data_o  = obs_valid_o ? mem_data[rptr] : 32'd0;
endmodule

// File: tb/tb_riscv_obs_tracer.sv
// Directed bench for riscv_obs_tracer (DEPTH=8, OBS_ALL=0) with hand-computed records.

module tb_riscv_obs_tracer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        retire_valid = 1'b0;
    logic [31:0] instr = '0, pc = '0, rs1_val = '0, rs2_val = '0, rd_val = '0;
    logic        obs_ready = 1'b0;
    logic        obs_valid;
    logic [2:0]  obs_kind;
    logic [31:0] obs_seq, obs_pc, obs_addr, obs_data;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    riscv_obs_tracer #(.DEPTH(8), .OBS_ALL(1'b0)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clear_i        (clear),
        .retire_valid_i (retire_valid),
        .instr_i        (instr),
        .pc_i           (pc),
        .rs1_val_i      (rs1_val),
        .rs2_val_i      (rs2_val),
        .rd_val_i       (rd_val),
        .obs_valid_o    (obs_valid),
        .obs_ready_i    (obs_ready),
        .obs_kind_o     (obs_kind),
        .obs_seq_o      (obs_seq),
        .obs_pc_o       (obs_pc),
        .obs_addr_o     (obs_addr),
        .obs_data_o     (obs_data),
        .count_o        (count),
        .overflow_o     (overflow),
        .drop_cnt_o     (drop_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // drivers: inputs change on the falling edge, outputs are sampled 1 time unit after the rising edge
    task automatic retire(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] d, input logic rdy);
        @(negedge clk);
        instr = i; pc = p; rs1_val = a; rs2_val = b; rd_val = d;
        retire_valid = 1'b1;
        obs_ready = rdy;
        @(posedge clk);
        #1;
        retire_valid = 1'b0;
        obs_ready = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        obs_ready = 1'b1;
        @(posedge clk);
        #1;
        obs_ready = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [2:0] k, input logic [31:0] s,
                              input logic [31:0] a, input logic [31:0] d);
        check({tag, "_valid"}, 32'(obs_valid), 32'd1);
        check({tag, "_kind"},  32'(obs_kind), 32'(k));
        check({tag, "_seq"},   obs_seq, s);
        check({tag, "_addr"},  obs_addr, a);
        check({tag, "_data"},  obs_data, d);
    endtask

    initial begin
        do_reset();
        #1;
        check("rst_valid", 32'(obs_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_drop",  32'(drop_cnt), 32'd0);
        check("rst_addr",  obs_addr, 32'd0);

        // LW x2, -4(x1)
        retire({12'hFFC, 5'd1, 3'b010, 5'd2, 7'b0000011}, 32'h40, 32'h1000, 32'h0, 32'hAB, 1'b0);
        check_head("lw", 3'd1, 32'd0, 32'h0000_0FFC, 32'hAB);
        check("lw_pc", obs_pc, 32'h40);
        @(posedge clk); #1;
        check("lw_hold_addr", obs_addr, 32'h0000_0FFC);
        pop();
        check("lw_popped", 32'(obs_valid), 32'd0);

        // BLT / BLTU x1, x2, +8
        retire({7'b0, 5'd2, 5'd1, 3'b100, 4'b0100, 1'b0, 7'b1100011}, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0);
        check_head("blt", 3'd3, 32'd1, 32'h108, 32'd1);
        pop();
        retire({7'b0, 5'd2, 5'd1, 3'b110, 4'b0100, 1'b0, 7'b1100011}, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0);
        check_head("bltu", 3'd3, 32'd2, 32'h108, 32'd0);
        pop();
        retire({7'b0, 5'd2, 5'd1, 3'b010, 4'b0100, 1'b0, 7'b1100011}, 32'h100, 32'h5, 32'h5, 32'h0, 1'b0);
        check_head("badbr", 3'd7, 32'd3, 32'h0, {7'b0, 5'd2, 5'd1, 3'b010, 4'b0100, 1'b0, 7'b1100011});
        pop();

        // JAL ra,+16 ; JAL x0,-4 ; JALR x1, 5(x1)
        retire(32'h0100_00EF, 32'h200, 32'h0, 32'h0, 32'h204, 1'b0);
        check_head("jal", 3'd4, 32'd4, 32'h210, 32'h204);
        pop();
        retire(32'hFFDF_F06F, 32'h300, 32'h0, 32'h0, 32'h0, 1'b0);
        check_head("jalneg", 3'd4, 32'd5, 32'h2FC, 32'h0);
        pop();
        retire({12'd5, 5'd1, 3'b000, 5'd1, 7'b1100111}, 32'h400, 32'h1000, 32'h0, 32'h404, 1'b0);
        check_head("jalr", 3'd4, 32'd6, 32'h1004, 32'h404);
        pop();

        // ALU suppressed, SW, illegal
        do_reset();
        retire({7'b0, 5'd3, 5'd1, 3'b000, 5'd2, 7'b0110011}, 32'h10, 32'd1, 32'd2, 32'd3, 1'b0);
        check("add_suppressed", 32'(count), 32'd0);
        retire({7'b0, 5'd2, 5'd1, 3'b010, 5'd8, 7'b0100011}, 32'h14, 32'h2000, 32'h55, 32'h0, 1'b0);
        check_head("sw", 3'd2, 32'd1, 32'h2008, 32'h55);
        pop();
        retire(32'hFFFF_FFFF, 32'h18, 32'h0, 32'h0, 32'h0, 1'b0);
        check_head("illegal", 3'd7, 32'd2, 32'h0, 32'hFFFF_FFFF);
        pop();

        // overflow: 10 loads into an 8-deep FIFO
        do_reset();
        for (int i = 0; i < 10; i++) begin
            retire({12'h004, 5'd1, 3'b010, 5'd2, 7'b0000011}, 32'h80, 32'h0, 32'h0, 32'(i), 1'b0);
            if (i < 8) exp_q.push_back(32'(i));
        end
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_flag",  32'(overflow), 32'd1);
        check("ovf_drop",  32'(drop_cnt), 32'd2);
        check("ovf_head_seq", obs_seq, exp_q.pop_front());

        // full, retire and pop in the same cycle: seq 10 goes in, seq 0 leaves
        retire({12'h004, 5'd1, 3'b010, 5'd2, 7'b0000011}, 32'h80, 32'h0, 32'h0, 32'h99, 1'b1);
        exp_q.push_back(32'd10);
        check("fullpp_count", 32'(count), 32'd8);
        check("fullpp_drop",  32'(drop_cnt), 32'd2);
        for (int k = 0; k < 8; k++) begin
            check("drain_seq", obs_seq, exp_q.pop_front());
            check("drain_data", obs_data, (k == 7) ? 32'h99 : 32'(k + 1));
            pop();
        end
        check("drain_empty", 32'(obs_valid), 32'd0);
        check("drain_zero_data", obs_data, 32'd0);

        // synchronous clear
        retire(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clr_count", 32'(count), 32'd0);
        check("clr_ovf",   32'(overflow), 32'd0);
        check("clr_drop",  32'(drop_cnt), 32'd0);
        retire(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        check("clr_seq", obs_seq, 32'd0);

        // asynchronous reset with 3 queued
        retire(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        retire(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        check("arst_pre_count", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(obs_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        retire({12'hFFC, 5'd1, 3'b010, 5'd2, 7'b0000011}, 32'h40, 32'h1000, 32'h0, 32'hAB, 1'b0);
        check_head("arst_next", 3'd1, 32'd0, 32'h0000_0FFC, 32'hAB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/riscv_obs_tracer.md
# riscv_obs_tracer

Downstream consumer of the instruction decoder in the verification harness. On each retired instruction it takes the retired instruction word plus operand/result values, decodes it via the decoder fields, and forms one observation record: memory address, branch outcome, jump target or ALU result. Records go into a FIFO that the contract checker drains through a valid/ready handshake. The block also keeps a retire sequence number and overflow/drop accounting, so a lost observation is always visible.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..64.
- OBS_ALL, 0: 1 = also emit records for ALU/LUI/AUIPC; 0 = suppress them.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- clear_i  in  1  synchronous clear of FIFO, overflow_o, drop_cnt_o, seq counter.
- retire_valid_i  in  1  one instruction retires this cycle.
- instr_i  in  32  retired instruction word.
- pc_i  in  32  PC of retired instruction.
- rs1_val_i  in  32  rs1 operand value.
- rs2_val_i  in  32  rs2 operand value.
- rd_val_i  in  32  value written to rd.
- obs_valid_o  out  1  FIFO head record valid.
- obs_ready_i  in  1  consumer accepts head.
- obs_kind_o  out  3  0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 7 ILLEGAL.
- obs_seq_o  out  32  retire sequence number of record.
- obs_pc_o  out  32  PC of record.
- obs_addr_o  out  32  effective address / target.
- obs_data_o  out  32  kind-specific data.
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow_o  out  1  sticky: a record was dropped.
- drop_cnt_o  out  16  dropped records, saturating.

## Operation
- Decode with a riscv_decoder instance on instr_i; the block sign-extends immediates itself from instr_i (decoder imm is not sign-extended).
- Record formation (all sums 32-bit, wrap modulo 2^32):
  - LOAD (op 0000011): addr = rs1_val + sext(instr[31:20]); data = rd_val.
  - STORE (op 0100011): addr = rs1_val + sext({instr[31:25],instr[11:7]}); data = rs2_val.
  - BRANCH (op 1100011): addr = pc + sext({instr[31],instr[7],instr[30:25],instr[11:8],0}); data = {31'b0, taken}. taken per funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. funct3 010/011 -> ILLEGAL.
  - JUMP: JAL addr = pc + sext J-imm; JALR addr = (rs1_val + sext(instr[31:20])) & ~1; data = rd_val.
  - ALU (R, OP-IMM, LUI, AUIPC): addr = 0, data = rd_val; emitted only if OBS_ALL=1.
  - ILLEGAL (decoder format TYPE_ERR or bad branch funct3): addr = 0, data = instr_i; always emitted.
- Sequence counter: increments on every retire_valid_i (emitted, suppressed or dropped); record carries pre-increment value; wraps 0xFFFFFFFF -> 0.
- FIFO: push when retire_valid_i and record emitted; pop when obs_valid_o & obs_ready_i.
  - Full, push, no pop: record dropped; overflow_o set; drop_cnt_o += 1, saturating at 0xFFFF.
  - Full, push and pop same cycle: both happen, count unchanged, no drop.
  - Empty, push and pop: pop ignored (obs_valid_o was 0).
  - Pointers wrap modulo DEPTH.
- clear_i has priority over push/pop in its cycle; all queued records discarded.

## Timing
- Reset/clear values: obs_valid_o 0, count_o 0, overflow_o 0, drop_cnt_o 0, seq 0; record outputs 0 while empty.
- Latency: retire at edge N -> record at head, obs_valid_o=1, after edge N (visible cycle N+1) when FIFO was empty.
- Record outputs stable while obs_valid_o=1 and obs_ready_i=0.
- Throughput: one push and one pop per cycle.
- rst_i mid-operation: outputs go to reset values immediately, no clock needed; queued records lost.

## Test plan
- LW, rs1_val=0x1000, imm=-4 (instr[31:20]=0xFFC), rd_val=0xAB -> kind 1, addr 0x00000FFC, data 0xAB, seq 0, valid one cycle after retire.
- BLT, rs1_val=0xFFFFFFFF, rs2_val=1, pc=0x100, imm=+8 -> kind 3, addr 0x108, data 1; same with BLTU -> data 0.
- DEPTH=8, obs_ready_i=0, 10 loads retired -> count_o 8, overflow_o 1, drop_cnt_o 2; drain -> seq 0..7 in order.
- FIFO full, retire and obs_ready_i=1 same cycle -> count_o stays 8, drop_cnt_o unchanged, new record last.
- OBS_ALL=0: ADD, then SW -> only STORE record, seq 1; instr 0xFFFFFFFF -> kind 7, data 0xFFFFFFFF.
- rst_i asserted asynchronously with 3 queued -> obs_valid_o 0, count_o 0 before next edge; next retire gets seq 0.
